// File: rtl/display_pack.sv
// Nibble-write front end for the seven-segment display path.
// Producers write 4-bit digit codes into a shadow word, either at an explicit digit index or
// at the next sequential index. A commit copies the whole shadow word to dig_o in one step, so
// the display scanner never sees a partly written value.
module display_pack #(
    parameter logic [31:0] RESET_DIG = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_valid_i,
    output logic        wr_ready_o,
    input  logic        wr_seq_i,
    input  logic [2:0]  wr_num_i,
    input  logic [3:0]  wr_code_i,
    input  logic        commit_i,
    input  logic        clear_i,
    output logic [31:0] dig_o,
    output logic        dig_upd_o,
    output logic [2:0]  ptr_o
);

    typedef enum logic [1:0] {
        StIdle,
        StDirty,
        StCommit
    } state_e;

    state_e      state_q;
    logic [31:0] shadow_q;
    logic [31:0] dig_q;
    logic [2:0]  ptr_q;
    logic        wr_ready_q;
    logic        dig_upd_q;

    logic        wr_accept;
    logic [2:0]  wr_idx;
    logic [31:0] shadow_wr;
    logic        seq_accept;
    logic        auto_commit;
    logic        becomes_dirty;
    logic        go_commit;
    logic [31:0] shadow_d;
    logic [2:0]  ptr_d;

    // Decode this cycle's write/clear/commit request into shadow, pointer and commit intent.
    always_comb begin
        wr_accept  = wr_valid_i & wr_ready_q;
        wr_idx     = wr_seq_i ? ptr_q : wr_num_i;
        seq_accept = wr_accept & wr_seq_i;

        // Replace only the addressed nibble.
        shadow_wr = shadow_q;
        for (int i = 0; i < 8; i++) begin
            if (3'(i) == wr_idx) begin
                shadow_wr[4*i +: 4] = wr_code_i;
            end
        end

        // A clear wins over a write issued in the same cycle.
        if (clear_i) begin
            shadow_d = RESET_DIG;
            ptr_d    = 3'd0;
        end else if (wr_accept) begin
            shadow_d = shadow_wr;
            ptr_d    = seq_accept ? ptr_q + 3'd1 : ptr_q;
        end else begin
            shadow_d = shadow_q;
            ptr_d    = ptr_q;
        end

        // The eighth sequential nibble commits on its own; a clear cancels that write.
        auto_commit   = seq_accept & (ptr_q == 3'd7) & ~clear_i;
        becomes_dirty = (state_q == StDirty) | wr_accept | clear_i;
        // A commit with nothing pending (idle, no write, no clear) is dropped.
        go_commit     = becomes_dirty & (commit_i | auto_commit);
    end

    // Control FSM with registered outputs; reset discards pending data without an update pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            shadow_q   <= RESET_DIG;
            dig_q      <= RESET_DIG;
            ptr_q      <= 3'd0;
            wr_ready_q <= 1'b1;
            dig_upd_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDirty: begin
                    shadow_q  <= shadow_d;
                    ptr_q     <= ptr_d;
                    dig_upd_q <= 1'b0;
                    if (go_commit) begin
                        state_q    <= StCommit;
                        wr_ready_q <= 1'b0;
                    end else if (becomes_dirty) begin
                        state_q    <= StDirty;
                        wr_ready_q <= 1'b1;
                    end else begin
                        state_q    <= StIdle;
                        wr_ready_q <= 1'b1;
                    end
                end
                StCommit: begin
                    // Requests seen here are ignored; writes are held off by wr_ready_o.
                    dig_q      <= shadow_q;
                    dig_upd_q  <= 1'b1;
                    wr_ready_q <= 1'b1;
                    state_q    <= StIdle;
                end
                default: begin
                    state_q    <= StIdle;
                    wr_ready_q <= 1'b1;
                    dig_upd_q  <= 1'b0;
                end
            endcase
        end
    end

    assign wr_ready_o = wr_ready_q;
    assign dig_o      = dig_q;
    assign dig_upd_o  = dig_upd_q;
    assign ptr_o      = ptr_q;

endmodule

// File: tb/tb_display_pack.sv
// Bench for display_pack: directed steps followed by random traffic, all checked every cycle
// against a nibble-array model of the shadow word, pointer and pending commit.
module tb_display_pack;

    localparam logic [31:0] ResetDig = 32'h1234_5678;

    logic        clk;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic        wr_seq;
    logic [2:0]  wr_num;
    logic [3:0]  wr_code;
    logic        commit;
    logic        clear;
    logic [31:0] dig;
    logic        dig_upd;
    logic [2:0]  ptr;

    display_pack #(
        .RESET_DIG (ResetDig)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wr_valid_i (wr_valid),
        .wr_ready_o (wr_ready),
        .wr_seq_i   (wr_seq),
        .wr_num_i   (wr_num),
        .wr_code_i  (wr_code),
        .commit_i   (commit),
        .clear_i    (clear),
        .dig_o      (dig),
        .dig_upd_o  (dig_upd),
        .ptr_o      (ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model.
    int          m_shadow [8];
    int          m_ptr;
    bit          m_dirty;
    bit          m_busy;
    logic [31:0] m_dig;
    bit          m_upd;
    bit          m_prev_upd;

    int n_checks;
    int n_fail;

    function automatic logic [31:0] pack_shadow();
        logic [31:0] w;
        w = 32'h0;
        for (int i = 0; i < 8; i++) w = w | (32'(m_shadow[i] & 15) << (4 * i));
        return w;
    endfunction

    task automatic load_reset_nibbles();
        for (int i = 0; i < 8; i++) m_shadow[i] = int'((ResetDig >> (4 * i)) & 32'hF);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int  idx;
        bit  acc;
        bit  auto_c;
        m_prev_upd = m_upd;
        if (rst) begin
            load_reset_nibbles();
            m_dig   = ResetDig;
            m_ptr   = 0;
            m_dirty = 0;
            m_busy  = 0;
            m_upd   = 0;
        end else if (m_busy) begin
            m_dig  = pack_shadow();
            m_upd  = 1;
            m_busy = 0;
        end else begin
            m_upd  = 0;
            acc    = wr_valid;
            idx    = wr_seq ? m_ptr : int'(wr_num);
            auto_c = acc && wr_seq && (m_ptr == 7) && !clear;
            if (clear) begin
                load_reset_nibbles();
                m_ptr   = 0;
                m_dirty = 1;
            end else if (acc) begin
                m_shadow[idx] = int'(wr_code);
                if (wr_seq) m_ptr = (m_ptr + 1) % 8;
                m_dirty = 1;
            end
            if (m_dirty && (commit || auto_c)) begin
                m_busy  = 1;
                m_dirty = 0;
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, then compare all outputs with the model.
    task automatic step(input bit r, input bit v, input bit s, input int num, input int code,
                        input bit cm, input bit cl);
        rst      = r;
        wr_valid = v;
        wr_seq   = s;
        wr_num   = 3'(num);
        wr_code  = 4'(code);
        commit   = cm;
        clear    = cl;
        @(posedge clk);
        model_step();
        #1;
        check("dig", dig, m_dig);
        check("dig_upd", 32'(dig_upd), 32'(m_upd));
        check("ptr", 32'(ptr), 32'(m_ptr));
        check("wr_ready", 32'(wr_ready), 32'(!m_busy));
        if (m_prev_upd) check("dig_upd_not_back_to_back", 32'(dig_upd), 32'd0);
        #3;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        m_upd      = 0;
        m_prev_upd = 0;
        rst = 1'b1; wr_valid = 1'b0; wr_seq = 1'b0; wr_num = 3'd0; wr_code = 4'd0;
        commit = 1'b0; clear = 1'b0;
        @(negedge clk);

        // Reset values.
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check("reset_dig_const", dig, 32'h1234_5678);
        idle();

        // Eight sequential writes 1..8 with auto-commit.
        for (int i = 1; i <= 8; i++) step(0, 1, 1, 0, i, 0, 0);
        idle();
        check("seq_auto_dig", dig, 32'h8765_4321);
        idle();

        // Random write, visible only after commit.
        step(0, 1, 0, 5, 10, 0, 0);
        idle();
        step(0, 0, 0, 0, 0, 1, 0);
        idle();
        check("rand_write_dig", dig, 32'h87A5_4321);
        idle();

        // Commit with nothing pending, then commit alongside a write.
        step(0, 0, 0, 0, 0, 1, 0);
        idle();
        step(0, 1, 0, 0, 15, 1, 0);
        idle();
        check("commit_with_write_dig", dig, 32'h87A5_432F);
        idle();

        // Partial sequence, clear, commit; next sequential write goes to digit 0.
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 9, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0);
        idle();
        check("clear_commit_dig", dig, ResetDig);
        step(0, 1, 1, 0, 12, 1, 0);
        idle();
        check("after_clear_seq_dig", dig, 32'h1234_567C);
        idle();

        // Commit together with clear transfers the reset value.
        step(0, 1, 0, 3, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1);
        idle();
        check("commit_clear_dig", dig, ResetDig);

        // Write held through the COMMIT cycle lands in the first ready cycle.
        step(0, 1, 0, 2, 6, 1, 0);
        step(0, 1, 0, 7, 3, 0, 0);
        step(0, 1, 0, 7, 3, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        idle();
        check("held_write_dig", dig, 32'h3234_5678);

        // Reset during the COMMIT cycle.
        step(0, 1, 0, 1, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        idle();
        idle();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0),
                 int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 15)),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 29) == 0));
        end
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/display_pack.md
# display_pack

Nibble-write front end for the seven-segment display path; the write-side counterpart of the digit-select logic that reads one 4-bit code per digit index out of a 32-bit digit word. Producers push 4-bit codes by digit index (random access) or in LSB-first sequence into a shadow word. A commit, explicit or automatic after the eighth sequential nibble, transfers the shadow word atomically to the `dig` output that drives the display scanner, so the display never shows a half-written value.

## Interface
- `RESET_DIG`, default 32'h0000_0000: value of `dig` and of the shadow word after reset; also the shadow value after `clear`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_valid` in 1: nibble write request.
- `wr_ready` out 1: write can be accepted this cycle. A write is accepted at the edge where `wr_valid & wr_ready`.
- `wr_seq` in 1: 1 means target index = internal `ptr` and `wr_num` is ignored; 0 means target index = `wr_num`.
- `wr_num` in 3: digit index for random writes; 0 is `dig[3:0]`, 7 is `dig[31:28]`.
- `wr_code` in 4: nibble value to write.
- `commit` in 1: request transfer of shadow to `dig`.
- `clear` in 1: shadow <= `RESET_DIG`, `ptr` <= 0.
- `dig` out 32: committed digit word; registered.
- `dig_upd` out 1: one-cycle pulse, high in the cycle `dig` first shows a newly committed value.
- `ptr` out 3: next sequential digit index.

## Operation
- State machine states:
  - IDLE: shadow equals `dig`.
  - DIRTY: shadow holds uncommitted changes.
  - COMMIT: one-cycle transfer state.
- Transitions:
  - IDLE -> DIRTY on an accepted write or on `clear`.
  - IDLE stays IDLE if `commit` is asserted alone; the commit is ignored and no `dig_upd` is produced.
  - DIRTY -> COMMIT on `commit`, or on an accepted sequential write with `ptr`=7 (auto-commit).
  - COMMIT -> IDLE unconditionally. At that edge `dig` <= shadow and `dig_upd` <= 1.
- `wr_ready` = 1 in IDLE and DIRTY, 0 in COMMIT. Writes are never lost: the producer holds `wr_valid` until it sees ready.
- Accepted write: shadow[4*idx+3 : 4*idx] <= `wr_code`. All other nibbles are unchanged.
- `ptr` rules:
  - Increments by 1 on every accepted sequential write.
  - Wraps 7 -> 0, 3-bit natural wrap.
  - Unaffected by random writes.
  - Reset to 0 by `rst` or `clear`.
- Simultaneous events in one cycle, in priority order:
  - `rst` overrides everything.
  - `clear` overrides a write: the write is not performed but is still counted as accepted if `wr_ready`=1, so the producer must not assert both. The state becomes DIRTY.
  - `commit` together with an accepted write in IDLE or DIRTY: the write lands in shadow first, and the commit transfers the shadow including that write.
  - `commit` together with `clear`: the commit transfers `RESET_DIG`.
  - `commit`, `clear` and writes during COMMIT are ignored. `wr_ready`=0 enforces this for writes.
- Reset mid-sequence or mid-commit:
  - Pending shadow data is discarded.
  - `dig` returns to `RESET_DIG`.
  - `dig_upd` is not pulsed.

## Timing
- Reset values: `dig`=`RESET_DIG`, shadow=`RESET_DIG`, `ptr`=0, state IDLE, `wr_ready`=1, `dig_upd`=0.
- Write latency: an accepted write at edge N is visible in shadow from cycle N+1. It is not visible on `dig` until committed.
- Commit latency: `commit` sampled at edge N (state DIRTY) gives state COMMIT during cycle N+1 with `wr_ready`=0. New `dig` and `dig_upd`=1 appear in cycle N+2, with `wr_ready`=1 again.
- Auto-commit latency: the 8th sequential write accepted at edge N gives new `dig` in cycle N+2. `ptr`=0 from cycle N+1.
- Minimum period of eight sequential writes plus commit: 9 cycles. The producer sees exactly one ready-low cycle.
- `dig_upd` is high for exactly one cycle per commit. It is never high in two consecutive cycles.

## Test plan
- Reset with `RESET_DIG`=32'h1234_5678 -> `dig`=32'h1234_5678, `ptr`=0, `wr_ready`=1, `dig_upd`=0.
- Sequential writes of codes 8,7,...,1 on consecutive cycles from reset value 0 -> `dig`=32'h1234_5678 two cycles after the 8th write, `dig_upd` one-cycle pulse, `wr_ready` low for exactly one cycle, `ptr`=0.
- Random write `wr_num`=5, `wr_code`=4'hA on `dig`=0, then `commit` -> `dig`=32'h00A0_0000. `dig` unchanged before the commit. `ptr` stays 0.
- `commit` in IDLE -> no `dig` change, no `dig_upd`. `commit` in the same cycle as a write of idx 0 code 4'hF -> `dig[3:0]`=4'hF after commit.
- Three sequential writes, then `clear`, then `commit` -> `dig`=`RESET_DIG`, `ptr`=0. The next sequential write targets `dig[3:0]`.
- `rst` asserted during the COMMIT cycle -> `dig`=`RESET_DIG` next cycle, no `dig_upd`, state IDLE. A `wr_valid` held during COMMIT is accepted in the first ready cycle.
